// File: rtl/qspi_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch port and the QSPI flash reader.
// Latency: a hit returns one cycle after the request is sampled in IDLE; a miss returns one cycle after the first f_rdy-high cycle.
// Backpressure: the core holds i_req until i_rdy pulses; f_trig is held until f_rdy is seen, and only one fill is outstanding at a time.
// Ports: clk/rst_n; fetch side i_req/i_addr -> i_rdy/i_data; flush; flash side f_trig/f_addr <- f_rdy/f_data;
//        hit_cnt/miss_cnt are saturating performance counters.
module qspi_fetch_cache #(
  parameter int LINES = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [23:0]      i_addr,
  output logic             i_rdy,
  output logic [31:0]      i_data,
  input  logic             flush,
  output logic             f_trig,
  output logic [23:0]      f_addr,
  input  logic             f_rdy,
  input  logic [31:0]      f_data,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 22 - IDX;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t             state, state_nxt;
  logic [LINES-1:0]   valid, valid_nxt;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];
  logic               flush_pend, flush_pend_nxt;
  logic               i_rdy_nxt, f_trig_nxt;
  logic [31:0]        i_data_nxt;
  logic [23:0]        f_addr_nxt;
  logic               hit_inc, miss_inc, fill_we;

  logic [IDX-1:0]     req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               hit, flush_now;
  logic               unused_addr_lsb;

  assign req_idx  = i_addr[IDX+1:2];
  assign req_tag  = i_addr[23:IDX+2];
  // Install from the latched flash address so a dropped i_req cannot corrupt the fill.
  assign fill_idx = f_addr[IDX+1:2];
  assign fill_tag = f_addr[23:IDX+2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // A flush seen in IDLE, live or deferred, wins over a same-cycle lookup.
  assign flush_now = flush || flush_pend;
  assign unused_addr_lsb = ^i_addr[1:0];

  always_comb begin
    state_nxt      = state;
    valid_nxt      = valid;
    flush_pend_nxt = flush_pend;
    i_rdy_nxt      = 1'b0;
    i_data_nxt     = i_data;
    f_trig_nxt     = f_trig;
    f_addr_nxt     = f_addr;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    fill_we        = 1'b0;
    case (state)
      IDLE: begin
        if (flush_now) begin
          valid_nxt      = '0;
          flush_pend_nxt = 1'b0;
        end
        if (i_req) begin
          if (hit && !flush_now) begin
            i_rdy_nxt  = 1'b1;
            i_data_nxt = data_mem[req_idx];
            hit_inc    = 1'b1;
            state_nxt  = RESP;
          end else begin
            f_trig_nxt = 1'b1;
            f_addr_nxt = {i_addr[23:2], 2'b00};
            miss_inc   = 1'b1;
            state_nxt  = FILL;
          end
        end
      end
      FILL: begin
        if (flush) flush_pend_nxt = 1'b1;
        // Dropping f_trig on the first f_rdy cycle keeps it low before f_rdy falls.
        if (f_rdy) begin
          fill_we             = 1'b1;
          valid_nxt[fill_idx] = 1'b1;
          i_data_nxt          = f_data;
          i_rdy_nxt           = 1'b1;
          f_trig_nxt          = 1'b0;
          state_nxt           = RESP;
        end
      end
      RESP: begin
        if (flush) flush_pend_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      flush_pend <= 1'b0;
      i_rdy      <= 1'b0;
      i_data     <= '0;
      f_trig     <= 1'b0;
      f_addr     <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      valid      <= valid_nxt;
      flush_pend <= flush_pend_nxt;
      i_rdy      <= i_rdy_nxt;
      i_data     <= i_data_nxt;
      f_trig     <= f_trig_nxt;
      f_addr     <= f_addr_nxt;
      if (hit_inc && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
      if (miss_inc && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  // Tag/data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= f_data;
    end
  end

endmodule

// File: tb/tb_qspi_fetch_cache.sv
module tb_qspi_fetch_cache;
  logic        clk, rst_n, i_req, flush, f_rdy;
  logic [23:0] i_addr;
  logic [31:0] f_data;
  logic        i_rdy, f_trig;
  logic [31:0] i_data;
  logic [23:0] f_addr;
  logic [3:0]  hit_cnt, miss_cnt;
  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  qspi_fetch_cache #(.LINES(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr),
    .i_rdy(i_rdy), .i_data(i_data), .flush(flush),
    .f_trig(f_trig), .f_addr(f_addr), .f_rdy(f_rdy), .f_data(f_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One fetch with a flash model that answers `delay` cycles after f_trig,
  // holding f_rdy for two cycles. flush_at: cycle to pulse flush (0 = with the request, -1 = never).
  task automatic fetch(input string name, input logic [23:0] addr, input logic [31:0] word,
                       input bit miss, input int delay, input int flush_at);
    int rdy_k, frdy_k, trigs, cd;
    bit prev_trig;
    rdy_k = 0; frdy_k = 0; trigs = 0; cd = -1; prev_trig = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_addr = addr; flush = (flush_at == 0);
    for (int k = 1; k <= 100 && rdy_k == 0; k++) begin
      @(negedge clk);
      flush = (k == flush_at);
      if (f_trig && !prev_trig) begin
        trigs++;
        check({name, "/f_addr"}, {8'h0, f_addr}, {8'h0, addr[23:2], 2'b00});
        cd = delay;
      end
      prev_trig = f_trig;
      if (f_rdy) check({name, "/trig_low_before_rdy_fall"}, {31'h0, f_trig}, 32'h0);
      if (i_rdy) begin
        rdy_k = k;
        check({name, "/data"}, i_data, word);
        i_req = 1'b0;
      end
      if (cd == 0 && frdy_k == 0) begin
        f_rdy = 1'b1; f_data = word; frdy_k = k;
      end else if (cd > 0) cd--;
    end
    check({name, "/done"}, {31'h0, rdy_k != 0}, 32'h1);
    check({name, "/latency"}, rdy_k, miss ? frdy_k + 1 : 1);
    check({name, "/flash_reads"}, trigs, {31'h0, miss});
    @(negedge clk);
    flush = 1'b0;
    check({name, "/rdy_pulse"}, {31'h0, i_rdy}, 32'h0);
    f_rdy = 1'b0;
    @(negedge clk);
    check({name, "/no_retrig"}, {31'h0, f_trig}, 32'h0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; i_req = 1'b0; flush = 1'b0; f_rdy = 1'b0;
    i_addr = '0; f_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst/i_rdy", {31'h0, i_rdy}, 32'h0);
    check("rst/i_data", i_data, 32'h0);
    check("rst/f_trig", {31'h0, f_trig}, 32'h0);
    check("rst/f_addr", {8'h0, f_addr}, 32'h0);
    check("rst/hit_cnt", {28'h0, hit_cnt}, 32'h0);
    check("rst/miss_cnt", {28'h0, miss_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    fetch("cold", 24'h000010, 32'hDEAD0004, 1'b1, 20, -1);
    check("cold/miss_cnt", {28'h0, miss_cnt}, 32'd1);
    fetch("rehit", 24'h000010, 32'hDEAD0004, 1'b0, 0, -1);
    check("rehit/hit_cnt", {28'h0, hit_cnt}, 32'd1);

    // Index 4 conflict: 0x10 and 0x50 evict each other.
    fetch("conf_a", 24'h000050, 32'h50505050, 1'b1, 3, -1);
    fetch("conf_b", 24'h000010, 32'hDEAD0004, 1'b1, 5, -1);
    check("conf/miss_cnt", {28'h0, miss_cnt}, 32'd3);

    // Flush during fill: data still returned, line dropped afterwards.
    fetch("fl_fill", 24'h000020, 32'h20202020, 1'b1, 10, 3);
    fetch("fl_after", 24'h000020, 32'h20202020, 1'b1, 4, -1);
    check("fl_after/miss_cnt", {28'h0, miss_cnt}, 32'd5);
    fetch("fl_hit", 24'h000020, 32'h20202020, 1'b0, 0, -1);
    check("fl_hit/hit_cnt", {28'h0, hit_cnt}, 32'd2);

    // Flush in IDLE, then flush coincident with the request.
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    fetch("fl_idle", 24'h000010, 32'hDEAD0004, 1'b1, 4, -1);
    fetch("fl_same", 24'h000010, 32'hDEAD0004, 1'b1, 4, 0);
    check("fl_same/miss_cnt", {28'h0, miss_cnt}, 32'd7);

    // Same index as 0x10, differing only in the top tag bit.
    fetch("hi_tag", 24'h800010, 32'h80000010, 1'b1, 3, -1);
    fetch("hi_tag_hit", 24'h800010, 32'h80000010, 1'b0, 0, -1);

    // Reset in the middle of a fill.
    @(negedge clk);
    i_req = 1'b1; i_addr = 24'h000030;
    repeat (4) @(negedge clk);
    check("rst_mid/filling", {31'h0, f_trig}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid/f_trig", {31'h0, f_trig}, 32'h0);
    check("rst_mid/f_addr", {8'h0, f_addr}, 32'h0);
    check("rst_mid/i_rdy", {31'h0, i_rdy}, 32'h0);
    check("rst_mid/i_data", i_data, 32'h0);
    check("rst_mid/hit_cnt", {28'h0, hit_cnt}, 32'h0);
    check("rst_mid/miss_cnt", {28'h0, miss_cnt}, 32'h0);
    @(negedge clk); i_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    fetch("post_rst", 24'h800010, 32'h80000010, 1'b1, 4, -1);
    check("post_rst/miss_cnt", {28'h0, miss_cnt}, 32'd1);

    // 20 hits on a 4-bit counter must stop at 15.
    for (int n = 0; n < 20; n++)
      fetch("sat", 24'h800010, 32'h80000010, 1'b0, 0, -1);
    check("sat/hit_cnt", {28'h0, hit_cnt}, 32'd15);
    check("sat/miss_cnt", {28'h0, miss_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qspi_fetch_cache.md
Name: qspi_fetch_cache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the core's instruction fetch port and the QSPI flash ROM reader (rom_qspi).
- Hits return in 1 cycle; misses issue one word read to the flash reader, install the word, and return it.
- Hit/miss counters support fetch-performance bring-up.

Parameters:
- LINES, 16, number of cache lines; power of 2, minimum 2; IDX = log2(LINES).
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held high with i_addr stable until i_rdy
- i_addr  in  24  fetch byte address; bits [1:0] ignored
- i_rdy  out  1  one-cycle pulse: i_data valid, request complete
- i_data  out  32  fetched instruction word
- flush  in  1  invalidate all lines (single-cycle pulse or level)
- f_trig  out  1  read request to flash reader (drives trigger_rd)
- f_addr  out  24  flash address (drives baddr): {i_addr[23:2], 2'b00}
- f_rdy  in  1  flash data valid (from brdy); high for at least 2 cycles per read
- f_data  in  32  flash word (from bdo)
- hit_cnt  out  CNT_W  saturating count of hits
- miss_cnt  out  CNT_W  saturating count of misses

Behaviour:
- Address split:
  - index = i_addr[IDX+1:2]
  - tag = i_addr[23:IDX+2]
  - Storage per line: valid bit, tag, 32-bit data, all in flops.
- Reset (async, rst_n low):
  - state = IDLE; all valid bits = 0.
  - i_rdy = 0, i_data = 0, f_trig = 0, f_addr = 0, hit_cnt = 0, miss_cnt = 0, flush_pend = 0.
  - Tag/data contents are don't-care.
- IDLE:
  - If i_req and hit (valid[index] and tag match): next cycle i_rdy = 1, i_data = line data, hit_cnt += 1. State → RESP.
  - If i_req and miss: f_addr latched, f_trig = 1, miss_cnt += 1. State → FILL.
- FILL:
  - f_trig and f_addr held until f_rdy is sampled high.
  - On the first cycle f_rdy is high:
    - Line written: valid = 1, tag, data = f_data.
    - i_data = f_data, i_rdy = 1 next cycle, f_trig = 0 next cycle.
    - State → RESP.
  - f_rdy high while in IDLE or RESP is ignored.
  - f_trig must be low before f_rdy falls, so the flash reader never re-triggers.
- RESP:
  - i_rdy high for exactly this cycle; state → IDLE.
  - A new request is evaluated in IDLE on the following cycle, so back-to-back hits complete every 2 cycles.
- Latency:
  - Hit: i_rdy 1 cycle after i_req is sampled in IDLE.
  - Miss: i_rdy 1 cycle after the first f_rdy-high cycle.
- Flush:
  - In IDLE with no pending request: all valid bits cleared that cycle. A request on the same cycle is treated as a miss.
  - During FILL or RESP: flush_pend set. The in-flight fill is still returned to the core and installed, then all valid bits are cleared on the first IDLE cycle (including the filled line).
  - A request arriving on that IDLE cycle is treated as a miss.
- i_req dropped while in FILL (protocol violation): fill still completes and installs; i_rdy still pulses.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Tag compare uses the full 24−IDX−2 upper address bits; no aliasing across the 16 MB space.

Test Plan:
- Cold miss: reset, i_addr=0x000010, flash model returns 0xDEAD0004 with f_rdy after 20 cycles → one f_trig pulse train with f_addr=0x000010; i_rdy 1 cycle after f_rdy; i_data=0xDEAD0004; miss_cnt=1.
- Re-fetch the same address → i_rdy on the cycle after the request; no f_trig; hit_cnt=1.
- Conflict (LINES=16): 0x000010, then 0x000050 (same index 4, different tag), then 0x000010 → 3 misses, 3 flash reads, correct data each time.
- f_rdy held high 2 cycles → exactly one line write and one i_rdy; f_trig low before f_rdy falls; no second flash read.
- Flush pulse during FILL for 0x000020 → core gets fill data; next fetch of 0x000020 misses (miss_cnt increments); flush in IDLE then fetch 0x000010 → miss.
- rst_n asserted mid-FILL → all outputs 0 immediately; after release, a previously cached address misses.
- Counter saturation with CNT_W=4: 20 hits → hit_cnt=15.
